// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state type and counter-width helper for bit-serial arithmetic
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..k.
  function automatic int cnt_width(input int k);
    return (k < 1) ? 1 : $clog2(k + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational subtract stage: D = A - B - BorrowIn
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BorrowIn,
  output logic D,
  output logic BorrowOut
);

  assign D         = A ^ B ^ BorrowIn;
  assign BorrowOut = (~A & B) | (~(A ^ B) & BorrowIn);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial K-bit subtractor, LSB first; optional Overflow under SERIAL_SUB_OVERFLOW_EN
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic         BorrowIn,
  output logic [K-1:0] O,
  output logic         BorrowOut,
  output logic         Busy,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic         Done,
  output logic         Overflow
`else
  output logic         Done
`endif
);

  localparam int            CW   = cnt_width(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_e        state_q, state_d;
  logic [K-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, o_q, o_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d, bo_q, bo_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          fs_d, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic          ovf_q, ovf_d;
`endif

  // Operands shift right so bit 0 always holds the bit being processed.
  full_subtractor u_fs (
    .A         (a_q[0]),
    .B         (b_q[0]),
    .BorrowIn  (borrow_q),
    .D         (fs_d),
    .BorrowOut (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    o_d      = o_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = BorrowIn;
          cnt_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        borrow_d     = fs_bout;
        res_d        = res_q >> 1;
        res_d[K-1]   = fs_d;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          o_d     = res_d;
          bo_d    = fs_bout;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // a_q[0]/b_q[0] now hold the original sign bits; fs_d is the result sign.
          ovf_d   = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      o_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      o_q      <= o_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign O         = o_q;
  assign BorrowOut = bo_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (K=8) against an arithmetic reference
module tb_serial_subtractor;

  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [K-1:0] A, B, O;
  logic         BorrowIn, BorrowOut, Busy, Done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         Overflow;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [K-1:0] last_o;

  serial_subtractor #(.K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .BorrowIn  (BorrowIn),
    .O         (O),
    .BorrowOut (BorrowOut),
    .Busy      (Busy),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .Done      (Done),
    .Overflow  (Overflow)
`else
    .Done      (Done)
`endif
  );

  always #5 clk = ~clk;

  // Caller must be at a negedge. Returns at the negedge of the Done cycle.
  task automatic run_sub(input logic [K-1:0] a, input logic [K-1:0] b, input logic bin,
                         input int poke, input string name);
    logic [K-1:0] eo;
    logic         eb;
    int           diff;
    int           busy_n;
    bit           got;
    diff = int'(a) - int'(b) - int'(bin);
    eo   = diff[K-1:0];
    eb   = (diff < 0);
    A = a; B = b; BorrowIn = bin; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = K'($urandom); B = K'($urandom); BorrowIn = 1'($urandom);
    busy_n = 0;
    got    = 0;
    for (int c = 0; c < 4 * K && !got; c++) begin
      checks++;
      if (Busy && Done) begin
        errors++;
        $display("FAIL %s busy_and_done together got Busy=%0b Done=%0b want not both", name, Busy, Done);
      end
      if (Done) got = 1;
      else begin
        if (Busy) busy_n++;
        checks++;
        if (O !== last_o) begin
          errors++;
          $display("FAIL %s hold_during_run got O=%h want %h", name, O, last_o);
        end
        if (busy_n == poke) begin
          Start = 1'b1; A = K'('hAA); B = '0;
        end else Start = 1'b0;
        @(negedge clk);
      end
    end
    Start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got no Done want Done within %0d cycles", name, 4 * K);
    end
    checks++;
    if (busy_n != K) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, K);
    end
    checks++;
    if (O !== eo || BorrowOut !== eb) begin
      errors++;
      $display("FAIL %s result got O=%h BorrowOut=%0b want O=%h BorrowOut=%0b", name, O, BorrowOut, eo, eb);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    begin
      logic eov;
      eov = (a[K-1] != b[K-1]) && (eo[K-1] != a[K-1]);
      checks++;
      if (Overflow !== eov) begin
        errors++;
        $display("FAIL %s overflow got %0b want %0b", name, Overflow, eov);
      end
    end
`endif
    last_o = eo;
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done got Done=%0b Busy=%0b want 0 0", name, Done, Busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; A = 8'h05; B = 8'h03; BorrowIn = 1'b0;
    last_o = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (O !== '0 || BorrowOut !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got O=%h Bo=%0b Busy=%0b Done=%0b want all 0", O, BorrowOut, Busy, Done);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %0b want 0", Overflow);
    end
`endif
    rst = 1'b0;
    run_sub(8'h05, 8'h03, 1'b0, -1, "first_after_reset");
    check_idle_after("first_after_reset");
  endtask

  task automatic test_directed();
    run_sub(8'h05, 8'h03, 1'b0, -1, "v_05_03");
    check_idle_after("v_05_03");
    run_sub(8'h00, 8'h01, 1'b0, -1, "v_00_01");
    check_idle_after("v_00_01");
    run_sub(8'h10, 8'h10, 1'b1, -1, "v_10_10_b1");
    check_idle_after("v_10_10_b1");
    run_sub(8'h80, 8'h01, 1'b0, -1, "v_80_01");
    check_idle_after("v_80_01");
    run_sub(8'hFF, 8'hFF, 1'b1, -1, "v_ff_ff_b1");
    check_idle_after("v_ff_ff_b1");
  endtask

  task automatic test_start_ignored();
    run_sub(8'h05, 8'h03, 1'b0, 3, "restart_ignored");
    check_idle_after("restart_ignored");
  endtask

  task automatic test_reset_midrun();
    A = 8'h05; B = 8'h03; BorrowIn = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (O !== '0 || BorrowOut !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got O=%h Bo=%0b Busy=%0b Done=%0b want all 0", O, BorrowOut, Busy, Done);
    end
    @(negedge clk);
    rst = 1'b0;
    last_o = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_done got Done=%0b Busy=%0b want 0 0", Done, Busy);
      end
    end
    run_sub(8'h09, 8'h04, 1'b0, -1, "after_midrun_reset");
    check_idle_after("after_midrun_reset");
  endtask

  task automatic test_back_to_back();
    run_sub(8'h3C, 8'h5A, 1'b0, -1, "b2b_0");
    run_sub(8'hC3, 8'h11, 1'b1, -1, "b2b_1");
    run_sub(8'h7F, 8'h80, 1'b0, -1, "b2b_2");
    check_idle_after("b2b_2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_sub(K'($urandom), K'($urandom), 1'($urandom), -1, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_idle_after("random_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter K, default 8, operand width in bits; legal range K >= 1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Start, input, 1, request to capture operands and begin a subtraction.
REQ-005 SHALL have ports A and B, input, K each; O = A - B.
REQ-006 SHALL have port BorrowIn, input, 1, borrow into bit 0.
REQ-007 SHALL have port O, output, K, difference result.
REQ-008 SHALL have port BorrowOut, output, 1, borrow out of bit K-1.
REQ-009 SHALL have port Busy, output, 1, high while a subtraction is in progress.
REQ-010 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port Overflow, output, 1, signed overflow flag; present only under SERIAL_SUB_OVERFLOW_EN.

Function
REQ-012 SHALL compute O = (A - B - BorrowIn) mod 2^K, with BorrowOut = 1 iff A < B + BorrowIn (unsigned).
REQ-013 SHALL process one bit per cycle, LSB first, through a registered borrow chain (bit-serial, no K-wide subtract).
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL sample Start only in IDLE or DONE; on acceptance at edge 0, A, B and BorrowIn are captured and the state becomes RUN.
REQ-016 SHALL compute bit i at edge i+1 (i = 0..K-1) while in RUN; after edge K the state is DONE.
REQ-017 SHALL hold Done high for exactly the cycle after edge K; at edge K+1 the state becomes IDLE, or RUN if Start is high.
REQ-018 SHALL hold Busy high exactly while in RUN; Busy and Done are never high together.
REQ-019 SHALL ignore Start in RUN; captured operands are not disturbed by input changes after capture.
REQ-020 SHALL update O and BorrowOut only at edge K; they hold their previous result throughout RUN and until the next completion.
REQ-021 SHALL take exactly one RUN cycle when K = 1 (Done in the cycle after edge 1).

Reset
REQ-022 SHALL, on rst, enter IDLE asynchronously and clear O, BorrowOut, Busy, Done, Overflow and all internal registers to 0.
REQ-023 SHALL discard a subtraction interrupted by rst; no Done pulse is produced for it.
REQ-024 SHALL ignore Start while rst is high; Start is first sampled at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, when SERIAL_SUB_OVERFLOW_EN is defined, provide Overflow = (A[K-1] != B[K-1]) && (O[K-1] != A[K-1]), updated at edge K alongside O.
REQ-026 SHALL, when SERIAL_SUB_OVERFLOW_EN is undefined, omit the Overflow port and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the state enumeration type (IDLE, RUN, DONE) from the shared package serial_arith_pkg.
REQ-028 SHALL take the bit-counter width constant, clog2 of K+1, from serial_arith_pkg.
REQ-029 SHALL instantiate one combinational sub-module, full_subtractor (inputs A, B, BorrowIn; outputs D, BorrowOut), for the per-bit stage.

Verification (K = 8)
REQ-030 SHALL cover: A=0x05, B=0x03, BorrowIn=0 -> O=0x02, BorrowOut=0, Done pulses in the cycle after edge 8.
REQ-031 SHALL cover: A=0x00, B=0x01, BorrowIn=0 -> O=0xFF, BorrowOut=1.
REQ-032 SHALL cover: A=0x10, B=0x10, BorrowIn=1 -> O=0xFF, BorrowOut=1.
REQ-033 SHALL cover: A=0x80, B=0x01, BorrowIn=0 -> O=0x7F, BorrowOut=0, Overflow=1 when SERIAL_SUB_OVERFLOW_EN is defined.
REQ-034 SHALL cover: Start re-pulsed with A=0xAA, B=0x00 at RUN cycle 3 of 0x05-0x03 -> ignored; result 0x02; Busy stays high for exactly 8 cycles.
REQ-035 SHALL cover: rst at RUN cycle 4 -> all outputs 0, no Done; the next Start (0x09-0x04) -> O=0x05.
